// File: rtl/ser_feed_pkg.sv
// ser_feed_pkg: shared types and limits for the ser_feed serialiser.
//   state_t      - feeder FSM encoding
//   DIV_MIN/MAX  - legal clocks-per-bit range
//   WIDTH_MIN/MAX- legal data word width range
//   div_cnt_w()  - divider counter width for a given DIV
package ser_feed_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   localparam int DIV_MIN   = 2;
   localparam int DIV_MAX   = 1023;
   localparam int WIDTH_MIN = 1;
   localparam int WIDTH_MAX = 16;

   function automatic int div_cnt_w(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/ser_feed_ce_gen.sv
// ce_gen: bit-rate strobe generator.
//   clk  - system clock
//   rn   - async active-low reset
//   en   - count enable
//   clr  - synchronous clear; next enabled cycle starts a fresh period
//   tick - registered strobe, high in the last cycle of every DIV-cycle period
module ce_gen
   import ser_feed_pkg::*;
#(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic rn,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = div_cnt_w(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] PRE  = CW'(DIV - 2);

   logic [CW-1:0] cnt;

   // tick is registered, so it is raised one count early to line up with cnt == LAST
   always_ff @(posedge clk or negedge rn) begin
      if (!rn) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (clr) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (en) begin
         cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
         tick <= (cnt == PRE);
      end else begin
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/ser_feed.sv
// ser_feed: parallel-to-serial feeder for a downstream 4-bit shift register.
//   clk    - system clock
//   rn     - async active-low reset
//   din    - parallel word, taken on dvalid && dready
//   dvalid - din valid
//   dready - ready for a word (IDLE only)
//   sli    - registered serial data, MSB first
//   ce     - registered one-cycle shift strobe per bit
//   busy   - high while a word is being shifted
//   done   - one-cycle pulse after the last bit's strobe
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | waiting for a word; sli at IDLE_LVL, dready=1
// ST_SHIFT | presenting bits; one ce per DIV cycles
module ser_feed
   import ser_feed_pkg::*;
#(
   parameter int   WIDTH    = 4,
   parameter int   DIV      = 10,
   parameter logic IDLE_LVL = 1'b0
) (
   input  logic             clk,
   input  logic             rn,
   input  logic [WIDTH-1:0] din,
   input  logic             dvalid,
   output logic             dready,
   output logic             sli,
   output logic             ce,
   output logic             busy,
   output logic             done
);

   generate
      if (DIV < DIV_MIN || DIV > DIV_MAX) begin : g_bad_div
         $fatal(1, "ser_feed: DIV out of range");
      end
      if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
         $fatal(1, "ser_feed: WIDTH out of range");
      end
   endgenerate

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state, state_nx;
   logic [WIDTH-1:0] shreg, shreg_nx;
   logic [BW-1:0]    bitcnt, bitcnt_nx;
   logic             sli_nx, done_nx;
   logic             tick;

   assign dready = (state == ST_IDLE);
   assign busy   = (state == ST_SHIFT);
   assign ce     = tick;

   // held clear in IDLE so the first bit period starts exactly at the handshake edge
   ce_gen #(.DIV(DIV)) u_ce_gen (
      .clk  (clk),
      .rn   (rn),
      .en   (busy),
      .clr  (dready),
      .tick (tick)
   );

   always_ff @(posedge clk or negedge rn) begin
      if (!rn) begin
         state  <= ST_IDLE;
         shreg  <= '0;
         bitcnt <= '0;
         sli    <= IDLE_LVL;
         done   <= 1'b0;
      end else begin
         state  <= state_nx;
         shreg  <= shreg_nx;
         bitcnt <= bitcnt_nx;
         sli    <= sli_nx;
         done   <= done_nx;
      end
   end

   // sli only moves on the edge that ends a ce cycle, so it is stable while ce=1
   always_comb begin
      state_nx  = state;
      shreg_nx  = shreg;
      bitcnt_nx = bitcnt;
      sli_nx    = sli;
      done_nx   = 1'b0;
      case (state)
         ST_IDLE: begin
            sli_nx = IDLE_LVL;
            if (dvalid) begin
               state_nx  = ST_SHIFT;
               shreg_nx  = din;
               bitcnt_nx = BW'(WIDTH - 1);
               sli_nx    = din[WIDTH-1];
            end
         end
         ST_SHIFT: begin
            if (tick) begin
               if (bitcnt == '0) begin
                  state_nx = ST_IDLE;
                  sli_nx   = IDLE_LVL;
                  done_nx  = 1'b1;
               end else begin
                  shreg_nx  = shreg << 1;
                  sli_nx    = shreg_nx[WIDTH-1];
                  bitcnt_nx = bitcnt - BW'(1);
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

endmodule
